// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: port encodings, default
// widths and the reserved word addresses used by the processor's firmware.
package mem_ctrl_pkg;

  // Which front-end port is serviced in a given cycle
  typedef enum logic [1:0] {
    PORT_IR      = 2'd0,
    PORT_DATA    = 2'd1,
    PORT_RESERVE = 2'd2,
    PORT_AUX     = 2'd3
  } port_e;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // Display syscall words and start of the program image
  localparam logic [6:0] DISP0     = 7'd28;
  localparam logic [6:0] DISP1     = 7'd29;
  localparam logic [6:0] DISP2     = 7'd30;
  localparam logic [6:0] DISP3     = 7'd31;
  localparam logic [6:0] PROG_BASE = 7'd32;

endpackage

// File: rtl/memory_controller_if.sv
// Bus bundle between the core and the memory controller: request strobe,
// port select, four request ports and their registered read-back data.
interface memory_controller_if #(
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W
);
  logic              en;
  logic [1:0]        state;
  logic              read0, read1, read2, read3;
  logic              write0, write1, write2, write3;
  logic [ADDR_W-1:0] address0, address1, address2, address3;
  logic [DATA_W-1:0] input_data0, input_data1, input_data2, input_data3;
  logic [DATA_W-1:0] output_data0, output_data1, output_data2, output_data3;
  logic              ready;

  modport master (
    output en, state,
    output read0, read1, read2, read3,
    output write0, write1, write2, write3,
    output address0, address1, address2, address3,
    output input_data0, input_data1, input_data2, input_data3,
    input  output_data0, output_data1, output_data2, output_data3,
    input  ready
  );

  modport slave (
    input  en, state,
    input  read0, read1, read2, read3,
    input  write0, write1, write2, write3,
    input  address0, address1, address2, address3,
    input  input_data0, input_data1, input_data2, input_data3,
    output output_data0, output_data1, output_data2, output_data3,
    output ready
  );
endinterface

// File: rtl/memory_controller_mem_array.sv
// Single-port RAM: synchronous write, combinational read. The controller's
// output registers turn the read into a one-cycle synchronous access.
// CLEAR_EN lets a clear pulse zero every word on the same posedge.
module mem_array #(
  parameter int ADDR_W   = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W   = mem_ctrl_pkg::DATA_W,
  parameter bit CLEAR_EN = 1'b0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Word storage: optional bulk clear, otherwise a single-word write
  always_ff @(posedge clk) begin
    if (CLEAR_EN && clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/memory_controller.sv
// Four-port time-multiplexed front end to one shared RAM. Only the port named
// by `state` is serviced; its result lands in that port's output register and
// `ready` pulses the cycle after every issued request.
// Optional feature: define MEMORY_CONTROLLER_CLEAR_ON_RESET_EN to have reset
// also zero the whole RAM; by default reset leaves RAM contents alone.
module memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  memory_controller_if.slave  bus
);
`ifdef MEMORY_CONTROLLER_CLEAR_ON_RESET_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic [DATA_W-1:0] out_q [4];
  logic              ready_q;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;

  // Route the request of the selected port to the shared RAM
  always_comb begin
    sel_read  = bus.read0;
    sel_write = bus.write0;
    sel_addr  = bus.address0;
    sel_wdata = bus.input_data0;
    case (port_e'(bus.state))
      PORT_DATA: begin
        sel_read  = bus.read1;
        sel_write = bus.write1;
        sel_addr  = bus.address1;
        sel_wdata = bus.input_data1;
      end
      PORT_RESERVE: begin
        sel_read  = bus.read2;
        sel_write = bus.write2;
        sel_addr  = bus.address2;
        sel_wdata = bus.input_data2;
      end
      PORT_AUX: begin
        sel_read  = bus.read3;
        sel_write = bus.write3;
        sel_addr  = bus.address3;
        sel_wdata = bus.input_data3;
      end
      default: ;
    endcase
  end

  // A write in a reset cycle is dropped so reset never corrupts RAM
  assign ram_we = bus.en & ~reset & sel_write;

  mem_array #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CLEAR_EN (CLEAR_EN)
  ) u_mem (
    .clk   (clk),
    .clear (reset),
    .we    (ram_we),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  // Per-port result registers (write-through, write wins) and ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        out_q[i] <= '0;
      end
      ready_q <= 1'b0;
    end else begin
      ready_q <= bus.en;
      if (bus.en && (sel_write || sel_read)) begin
        out_q[bus.state] <= sel_write ? sel_wdata : ram_rdata;
      end
    end
  end

  assign bus.output_data0 = out_q[0];
  assign bus.output_data1 = out_q[1];
  assign bus.output_data2 = out_q[2];
  assign bus.output_data3 = out_q[3];
  assign bus.ready        = ready_q;
endmodule

// File: tb/tb_memory_controller.sv
// Testbench for memory_controller: directed scenarios plus randomized traffic,
// all checked every cycle against a word-array reference model.
module tb_memory_controller;
  logic clk = 1'b0;
  logic reset;

  memory_controller_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  memory_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Per-port request values driven onto the bus by applyStimulus
  logic       rd_v [4];
  logic       wr_v [4];
  logic [6:0] a_v  [4];
  logic [7:0] d_v  [4];

  // Reference model state
  logic [7:0] m_mem [128];
  logic [7:0] m_out [4];
  logic       m_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] saved;

  // Single comparison point: count it and report any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearReq();
    for (int p = 0; p < 4; p++) begin
      rd_v[p] = 1'b0;
      wr_v[p] = 1'b0;
      a_v[p]  = 7'd0;
      d_v[p]  = 8'd0;
    end
  endtask

  task automatic setPort(input int p, input logic rd, input logic wr, input logic [6:0] a, input logic [7:0] d);
    rd_v[p] = rd;
    wr_v[p] = wr;
    a_v[p]  = a;
    d_v[p]  = d;
  endtask

  // Drive one cycle, advance the model by the same rules, then compare all outputs
  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [1:0] st_v);
    int s;
    reset = rst_v;
    bus.en = en_v;
    bus.state = st_v;
    bus.read0 = rd_v[0];  bus.read1 = rd_v[1];  bus.read2 = rd_v[2];  bus.read3 = rd_v[3];
    bus.write0 = wr_v[0]; bus.write1 = wr_v[1]; bus.write2 = wr_v[2]; bus.write3 = wr_v[3];
    bus.address0 = a_v[0]; bus.address1 = a_v[1]; bus.address2 = a_v[2]; bus.address3 = a_v[3];
    bus.input_data0 = d_v[0]; bus.input_data1 = d_v[1];
    bus.input_data2 = d_v[2]; bus.input_data3 = d_v[3];
    @(posedge clk);
    s = int'(st_v);
    if (rst_v) begin
      for (int p = 0; p < 4; p++) m_out[p] = 8'h00;
      m_ready = 1'b0;
`ifdef MEMORY_CONTROLLER_CLEAR_ON_RESET_EN
      for (int i = 0; i < 128; i++) m_mem[i] = 8'h00;
`endif
    end else begin
      m_ready = en_v;
      if (en_v && wr_v[s]) begin
        m_mem[a_v[s]] = d_v[s];
        m_out[s] = d_v[s];
      end else if (en_v && rd_v[s]) begin
        m_out[s] = m_mem[a_v[s]];
      end
    end
    #1;
    checkOutput("out0", {24'd0, bus.output_data0}, {24'd0, m_out[0]});
    checkOutput("out1", {24'd0, bus.output_data1}, {24'd0, m_out[1]});
    checkOutput("out2", {24'd0, bus.output_data2}, {24'd0, m_out[2]});
    checkOutput("out3", {24'd0, bus.output_data3}, {24'd0, m_out[3]});
    checkOutput("ready", {31'd0, bus.ready}, {31'd0, m_ready});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_mem[i] = 8'hxx;
    for (int p = 0; p < 4; p++) m_out[p] = 8'hxx;
    m_ready = 1'bx;
    clearReq();

    // Initial reset
    applyStimulus(1'b1, 1'b0, 2'd0);
    checkOutput("rst_out0", {24'd0, bus.output_data0}, 32'h0);
    checkOutput("rst_ready", {31'd0, bus.ready}, 32'h0);

    // Fill every word with random data through rotating ports
    for (int i = 0; i < 128; i++) begin
      clearReq();
      setPort(i % 4, 1'b0, 1'b1, 7'(i), 8'($urandom_range(255)));
      applyStimulus(1'b0, 1'b1, 2'(i % 4));
    end

    // Reset with a pending port-1 write: write is dropped, outputs cleared
    clearReq();
    setPort(1, 1'b0, 1'b1, 7'd40, 8'h99);
    saved = m_mem[40];
    applyStimulus(1'b1, 1'b1, 2'd1);
    applyStimulus(1'b1, 1'b1, 2'd1);
    checkOutput("rst2_out1", {24'd0, bus.output_data1}, 32'h0);
    checkOutput("rst2_ready", {31'd0, bus.ready}, 32'h0);
    clearReq();
    setPort(1, 1'b1, 1'b0, 7'd40, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd1);
`ifdef MEMORY_CONTROLLER_CLEAR_ON_RESET_EN
    checkOutput("rst_keep40", {24'd0, bus.output_data1}, 32'h0);
`else
    checkOutput("rst_keep40", {24'd0, bus.output_data1}, {24'd0, saved});
`endif

    // Port 1 write then read back
    clearReq();
    setPort(1, 1'b0, 1'b1, 7'd40, 8'hA5);
    applyStimulus(1'b0, 1'b1, 2'd1);
    checkOutput("wr_a5", {24'd0, bus.output_data1}, 32'hA5);
    checkOutput("wr_ready", {31'd0, bus.ready}, 32'h1);
    clearReq();
    setPort(1, 1'b1, 1'b0, 7'd40, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd1);
    checkOutput("rd_a5", {24'd0, bus.output_data1}, 32'hA5);

    // Port isolation: port 2 writes while port 0 also requests
    clearReq();
    saved = m_out[0];
    setPort(2, 1'b0, 1'b1, 7'd28, 8'h3C);
    setPort(0, 1'b1, 1'b0, 7'd28, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd2);
    checkOutput("iso_out0", {24'd0, bus.output_data0}, {24'd0, saved});
    clearReq();
    setPort(0, 1'b1, 1'b0, 7'd28, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd0);
    checkOutput("iso_rd0", {24'd0, bus.output_data0}, 32'h3C);
    checkOutput("iso_out2", {24'd0, bus.output_data2}, 32'h3C);

    // Streaming reads of 32..35 after preloading 0x10..0x13
    for (int i = 0; i < 4; i++) begin
      clearReq();
      setPort(1, 1'b0, 1'b1, 7'(32 + i), 8'(16 + i));
      applyStimulus(1'b0, 1'b1, 2'd1);
    end
    for (int i = 0; i < 4; i++) begin
      clearReq();
      setPort(0, 1'b1, 1'b0, 7'(32 + i), 8'h00);
      applyStimulus(1'b0, 1'b1, 2'd0);
      checkOutput("stream_data", {24'd0, bus.output_data0}, 32'(16 + i));
      checkOutput("stream_ready", {31'd0, bus.ready}, 32'h1);
    end

    // Read+write conflict at the top address, then an idle cycle
    clearReq();
    setPort(3, 1'b1, 1'b1, 7'd127, 8'h77);
    applyStimulus(1'b0, 1'b1, 2'd3);
    checkOutput("conf_out3", {24'd0, bus.output_data3}, 32'h77);
    checkOutput("conf_mem", {24'd0, m_mem[127]}, 32'h77);
    applyStimulus(1'b0, 1'b0, 2'd3);
    checkOutput("idle_ready", {31'd0, bus.ready}, 32'h0);
    checkOutput("idle_out3", {24'd0, bus.output_data3}, 32'h77);
    clearReq();
    setPort(3, 1'b1, 1'b0, 7'd127, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd3);
    checkOutput("conf_rd127", {24'd0, bus.output_data3}, 32'h77);

    // Reset clear option: write FF at 5, reset, read 5
    clearReq();
    setPort(1, 1'b0, 1'b1, 7'd5, 8'hFF);
    applyStimulus(1'b0, 1'b1, 2'd1);
    clearReq();
    applyStimulus(1'b1, 1'b0, 2'd0);
    setPort(1, 1'b1, 1'b0, 7'd5, 8'h00);
    applyStimulus(1'b0, 1'b1, 2'd1);
`ifdef MEMORY_CONTROLLER_CLEAR_ON_RESET_EN
    checkOutput("clr_rd5", {24'd0, bus.output_data1}, 32'h00);
`else
    checkOutput("clr_rd5", {24'd0, bus.output_data1}, 32'hFF);
`endif

    // Randomized traffic on all ports with occasional idle and reset cycles
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++) begin
        setPort(p, 1'($urandom_range(1)), 1'($urandom_range(3) == 0),
                7'($urandom_range(127)), 8'($urandom_range(255)));
      end
      applyStimulus(1'($urandom_range(49) == 0), 1'($urandom_range(7) != 0),
                    2'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
